// File: rtl/period_meter_pkg.sv
// Shared state encoding and averaging constants for the period meter.
package period_meter_pkg;

    localparam logic S_IDLE    = 1'b0;
    localparam logic S_MEASURE = 1'b1;

    typedef enum logic {
        IDLE    = S_IDLE,
        MEASURE = S_MEASURE
    } state_e;

    localparam int AVG_DEPTH = 4;
    localparam int AVG_LOG2  = 2;

endpackage

// File: rtl/period_avg4.sv
// Four-sample period accumulator; out_last flags that the next sample
// completes a group, and out_period is that group's truncated mean.
module period_avg4
    import period_meter_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_period,
    output logic             out_last,
    output logic [WIDTH-1:0] out_period
);

    logic [WIDTH+1:0]    sum_q, sum_d, sum_next;
    logic [AVG_LOG2-1:0] idx_q, idx_d;

    always_comb begin
        sum_next   = sum_q + {2'b00, in_period};
        sum_d      = sum_q;
        idx_d      = idx_q;
        out_last   = (idx_q == AVG_LOG2'(AVG_DEPTH - 1));
        out_period = sum_next[WIDTH+1:AVG_LOG2];
        if (clr) begin
            sum_d = '0;
            idx_d = '0;
        end else if (in_valid) begin
            if (out_last) begin
                sum_d = '0;
                idx_d = '0;
            end else begin
                sum_d = sum_next;
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            idx_q <= '0;
        end else begin
            sum_q <= sum_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Tick-to-tick period meter with timeout stall detection.
// Optional four-sample averaging via PERIOD_METER_AVG_EN.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    output logic             stall
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stall_q, stall_d;

`ifdef PERIOD_METER_AVG_EN
    logic             meas_done;
    logic             avg_clr;
    logic             avg_last;
    logic [WIDTH-1:0] avg_period;

    period_avg4 #(
        .WIDTH(WIDTH)
    ) u_avg (
        .clk       (clk),
        .reset     (reset),
        .clr       (avg_clr),
        .in_valid  (meas_done),
        .in_period (cnt_q),
        .out_last  (avg_last),
        .out_period(avg_period)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        stall_d  = stall_q;
`ifdef PERIOD_METER_AVG_EN
        meas_done = 1'b0;
        avg_clr   = 1'b0;
`endif
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef PERIOD_METER_AVG_EN
            avg_clr = 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tick) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                        stall_d = 1'b0;
                    end
                end
                MEASURE: begin
                    // A tick on the terminal count still counts as a period.
                    if (tick) begin
                        cnt_d = CNT_ONE;
`ifdef PERIOD_METER_AVG_EN
                        meas_done = 1'b1;
                        if (avg_last) begin
                            period_d = avg_period;
                            valid_d  = 1'b1;
                        end
`else
                        period_d = cnt_q;
                        valid_d  = 1'b1;
`endif
                    end else if (cnt_q == CNT_MAX) begin
                        state_d  = IDLE;
                        stall_d  = 1'b1;
                        period_d = '0;
                        valid_d  = 1'b1;
`ifdef PERIOD_METER_AVG_EN
                        avg_clr = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
        end
    end

    assign period = period_q;
    assign valid  = valid_q;
    assign stall  = stall_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter (WIDTH=8): directed scenarios plus random ticks,
// compared every cycle against a timestamp-based reference model.
module tb_period_meter;

    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic         tick;
    logic         en;
    logic [W-1:0] period;
    logic         valid;
    logic         stall;

    period_meter #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .en    (en),
        .period(period),
        .valid (valid),
        .stall (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: remembers when the measurement was armed / last
    // ticked and derives everything from elapsed cycle numbers.
    int     cyc   = 0;
    bit     armed = 0;
    int     last  = 0;
    int     m_period = 0;
    bit     m_valid  = 0;
    bit     m_stall  = 0;
    int     samples[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    task automatic record(input int k);
`ifdef PERIOD_METER_AVG_EN
        int sum;
        samples.push_back(k);
        if (samples.size() == 4) begin
            sum = 0;
            foreach (samples[i]) sum += samples[i];
            m_period = sum / 4;
            m_valid  = 1;
            samples.delete();
        end
`else
        m_period = k;
        m_valid  = 1;
`endif
    endtask

    task automatic model_step(input bit tk, input bit e, input bit r);
        int k;
        cyc++;
        m_valid = 0;
        if (r) begin
            armed = 0;
            m_period = 0;
            m_stall = 0;
            samples.delete();
        end else if (!e) begin
            armed = 0;
            samples.delete();
        end else if (!armed) begin
            if (tk) begin
                armed = 1;
                last = cyc;
                m_stall = 0;
            end
        end else begin
            k = cyc - last;
            if (tk) begin
                last = cyc;
                record(k);
            end else if (k == MAXC) begin
                armed = 0;
                m_stall = 1;
                m_period = 0;
                m_valid = 1;
                samples.delete();
            end
        end
    endtask

    task automatic step(input bit tk, input bit e, input bit r);
        tick  = tk;
        en    = e;
        reset = r;
        @(posedge clk);
        model_step(tk, e, r);
        #1;
        check("valid",  {31'd0, valid}, {31'd0, m_valid});
        check("period", {24'd0, period}, 32'(m_period));
        check("stall",  {31'd0, stall}, {31'd0, m_stall});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        tick  = 1'b0;
        en    = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);

        // Ticks at 10, 15, 16 relative to start.
        idle(9);
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Timeout, re-arm without valid, then period 3.
        idle(300);
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 1'b0);

        // Tick coincident with terminal count.
        idle(254);
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b1, 1'b0);

        // en dropped together with a tick mid-measurement.
        idle(5);
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 1'b1, 1'b0);

        // Reset mid-measurement, then 5-cycle ticks.
        idle(39);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            idle(4);
        end

        // Random segments with varying tick density.
        for (int s = 0; s < 30; s++) begin
            int prob;
            int len;
            case ($urandom_range(0, 4))
                0: prob = 0;
                1: prob = 1;
                2: prob = 10;
                3: prob = 40;
                default: prob = 90;
            endcase
            len = $urandom_range(50, 320);
            for (int i = 0; i < len; i++) begin
                bit tk;
                bit e;
                bit r;
                tk = ($urandom_range(0, 99) < prob);
                e  = ($urandom_range(0, 99) >= 2);
                r  = ($urandom_range(0, 199) == 0);
                step(tk, e, r);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 24, giving the period/counter width in bits (minimum 4).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tick  input  1  one-cycle event pulse from the upstream edge trigger.
REQ-005 SHALL have port en  input  1  measurement enable; low forces IDLE.
REQ-006 SHALL have port period  output  WIDTH  last measured tick-to-tick distance in clk cycles, registered.
REQ-007 SHALL have port valid  output  1  one-cycle strobe marking a new period value.
REQ-008 SHALL have port stall  output  1  level; high while the input has timed out.

Function
REQ-009 SHALL implement states IDLE (unarmed) and MEASURE (counting since the last tick).
REQ-010 In IDLE with en=1 and tick=1, SHALL load cnt<=1 and enter MEASURE; no valid; stall<=0.
REQ-011 In MEASURE without tick, SHALL increment cnt by 1 per cycle.
REQ-012 In MEASURE with tick, SHALL register period<=cnt and valid<=1 on the same edge, then reload cnt<=1; valid is high in the cycle after the tick (latency 1).
REQ-013 Ticks on cycles N and N+k SHALL yield period=k; back-to-back ticks SHALL yield period=1.
REQ-014 In MEASURE with no tick and cnt = 2^WIDTH-1, SHALL enter IDLE, set stall<=1, period<=0, and pulse valid.
REQ-015 On simultaneous tick and terminal count, the tick SHALL win: period<=2^WIDTH-1, valid pulses, stall stays 0, remain in MEASURE.
REQ-016 The first tick after stall SHALL only re-arm (REQ-010); no valid is produced for it.
REQ-017 en=0 SHALL force IDLE and clear cnt on the next edge, overriding any tick in that cycle; period and stall hold; valid<=0.
REQ-018 valid SHALL never be high for two consecutive cycles.

Reset
REQ-019 reset=1 SHALL set state=IDLE, cnt=0, period=0, valid=0, stall=0 on the next clk edge, overriding en and tick.
REQ-020 Reset asserted mid-measurement SHALL discard the partial count; the next tick after release only arms.

Configuration
REQ-021 With macro PERIOD_METER_AVG_EN defined, SHALL accumulate four consecutive measurements in a WIDTH+2-bit sum and pulse valid only on every fourth measurement, with period = sum>>2 (truncating).
REQ-022 With PERIOD_METER_AVG_EN defined, stall, en=0, and reset SHALL clear the sum and the 2-bit sample counter; the stall report of REQ-014 is emitted immediately regardless of sample count.
REQ-023 Without PERIOD_METER_AVG_EN, SHALL behave per REQ-012 with no accumulator logic synthesised.

Structure
REQ-024 State encoding localparams (IDLE, MEASURE) and the averaging depth constant (4, log2 = 2) SHALL reside in shared package/include period_meter_pkg.
REQ-025 The averaging accumulator SHALL be a sub-module period_avg4, instantiated only under PERIOD_METER_AVG_EN.

Verification
REQ-026 WIDTH=8, en=1, ticks at cycles 10, 15, 16 -> valid at 16 with period=5 and at 17 with period=1; no valid for cycle 10.
REQ-027 WIDTH=8, single tick at cycle 10, none after -> at cycle 265, valid=1, period=0, stall=1; next tick at 300 -> stall=0 and no valid; tick at 303 -> period=3.
REQ-028 WIDTH=8, tick coincident with cnt=255 -> period=255, valid=1, stall=0.
REQ-029 en dropped in the same cycle as a tick, mid-measurement -> no valid, period holds previous value; after en returns, the first tick arms only.
REQ-030 reset pulsed during MEASURE with cnt=40 -> period=0, valid=0, stall=0; following ticks at 5-cycle spacing -> first valid reports period=5.
REQ-031 With PERIOD_METER_AVG_EN, periods 4, 5, 6, 8 -> a single valid after the fourth with period=5 (23>>2).
